// File: rtl/tt_pkg.sv
// Shared types for the truth-table evaluator: FSM states, row record and depth helper.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROG = 2'd1,
    RUN  = 2'd2
  } tt_state_e;

  localparam int MAX_OUT = 32;

  typedef struct packed {
    logic [MAX_OUT-1:0] data;
    logic [MAX_OUT-1:0] mask;
  } tt_row_t;

  function automatic int depth(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_row_mem.sv
// Row register file: one write port, one asynchronous read port.
// Mask storage exists only when TT_DONTCARE_EN is defined; otherwise every bit reads as care.
module tt_row_mem
  import tt_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [N_IN-1:0]  waddr,
  input  logic [N_OUT-1:0] wdata,
  input  logic [N_OUT-1:0] wmask,
  input  logic [N_IN-1:0]  raddr,
  output logic [N_OUT-1:0] rdata,
  output logic [N_OUT-1:0] rmask
);

  localparam int DEPTH = depth(N_IN);

  logic [N_OUT-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else if (we) begin
      data_q[waddr] <= wdata;
    end
  end

  assign rdata = data_q[raddr];

`ifdef TT_DONTCARE_EN
  logic [N_OUT-1:0] mask_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mask_q[i] <= '1;
    end else if (we) begin
      mask_q[waddr] <= wmask;
    end
  end

  assign rmask = mask_q[raddr];
`else
  logic unused_wmask;
  assign unused_wmask = ^wmask;
  assign rmask        = '1;
`endif

endmodule

// File: rtl/tt_eval_engine.sv
// Programmable truth-table evaluator: serial row programming, then a 1-cycle-latency valid/ready lookup stream.
// Optional don't-care masks are enabled with TT_DONTCARE_EN.
module tt_eval_engine
  import tt_pkg::*;
#(
  parameter int   N_IN    = 3,
  parameter int   N_OUT   = 2,
  parameter logic DC_FILL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_we,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic [N_OUT-1:0] cfg_mask,
  output logic             cfg_done,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic [N_OUT-1:0] out_dc,
  output tt_state_e        dbg_state
);

  localparam logic [N_IN-1:0] LAST = N_IN'(depth(N_IN) - 1);

  tt_state_e        state;
  logic [N_IN-1:0]  cnt;
  logic             wr_en;
  logic             accept;
  logic [N_OUT-1:0] rd_data;
  logic [N_OUT-1:0] rd_mask;

  // Valid/ready: a beat moves when valid && ready on a rising edge; a presented
  // result holds its data until taken, and a stalled output blocks new inputs.
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign wr_en     = cfg_we && !cfg_start && (state == PROG);
  assign dbg_state = state;

  tt_row_mem #(.N_IN(N_IN), .N_OUT(N_OUT)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (cnt),
    .wdata (cfg_data),
    .wmask (cfg_mask),
    .raddr (in_vec),
    .rdata (rd_data),
    .rmask (rd_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (cfg_start) begin
        // A write presented alongside start is dropped.
        state   <= PROG;
        cnt     <= '0;
        cfg_err <= 1'b0;
      end else if (cfg_we) begin
        if (state == PROG) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= RUN;
            cfg_done <= 1'b1;
          end
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= (rd_data & rd_mask) | ({N_OUT{DC_FILL}} & ~rd_mask);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef TT_DONTCARE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_dc <= '0;
    else if (accept) out_dc <= ~rd_mask;
  end
`else
  assign out_dc = '0;
`endif

endmodule

// File: tb/tb_tt_eval_engine.sv
// Bench for tt_eval_engine: random tables and vectors checked against a row-array reference model.
module tb_tt_eval_engine;
  import tt_pkg::*;

  localparam int N_IN  = 3;
  localparam int N_OUT = 2;
  localparam int ROWS  = 8;
  localparam int W     = 3 * N_OUT;
`ifdef TT_DONTCARE_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_start, cfg_we;
  logic [N_OUT-1:0] cfg_data, cfg_mask;
  logic             in_valid, out_ready;
  logic [N_IN-1:0]  in_vec;
  logic             cfg_done, cfg_err, in_ready, out_valid;
  logic [N_OUT-1:0] out_data, out_dc;
  tt_state_e        dbg_state;
  logic             cfg_done_1, cfg_err_1, in_ready_1, out_valid_1;
  logic [N_OUT-1:0] out_data_1, out_dc_1;
  tt_state_e        dbg_state_1;

  tt_row_t          model [ROWS];
  bit               running;
  logic [W-1:0]     exp_q[$];
  logic [N_OUT-1:0] prog_d [ROWS];
  logic [N_OUT-1:0] prog_m [ROWS];
  int               vectors, miscompares;

  always #5 clk = ~clk;

  tt_eval_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DC_FILL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_we(cfg_we),
    .cfg_data(cfg_data), .cfg_mask(cfg_mask), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_dc(out_dc), .dbg_state(dbg_state)
  );

  tt_eval_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DC_FILL(1'b1)) dut_fill1 (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_we(cfg_we),
    .cfg_data(cfg_data), .cfg_mask(cfg_mask), .cfg_done(cfg_done_1), .cfg_err(cfg_err_1),
    .in_valid(in_valid), .in_ready(in_ready_1), .in_vec(in_vec), .out_valid(out_valid_1),
    .out_ready(out_ready), .out_data(out_data_1), .out_dc(out_dc_1), .dbg_state(dbg_state_1)
  );

  function automatic logic [N_OUT-1:0] ref_data(input int idx, input logic fill);
    logic [N_OUT-1:0] r;
    for (int b = 0; b < N_OUT; b++)
      r[b] = (DC_EN && !model[idx].mask[b]) ? fill : model[idx].data[b];
    return r;
  endfunction

  function automatic logic [N_OUT-1:0] ref_dc(input int idx);
    logic [N_OUT-1:0] r;
    for (int b = 0; b < N_OUT; b++) r[b] = DC_EN && !model[idx].mask[b];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ROWS; i++) begin
      model[i].data = '0;
      model[i].mask = '1;
    end
    running = 1'b0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic random_table();
    for (int i = 0; i < ROWS; i++) begin
      prog_d[i] = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
      prog_m[i] = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
    end
  endtask

  task automatic program_table(input bit collide, input int n_rows);
    cfg_start = 1'b1;
    cfg_we    = collide;
    cfg_data  = ~prog_d[0];
    cfg_mask  = '1;
    tick();
    cfg_start = 1'b0;
    cfg_we    = 1'b0;
    running   = 1'b0;
    #1;
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++; $display("FAIL cfg_err_after_start: got %0b expected 0", cfg_err);
    end
    vectors++;
    if (dbg_state !== PROG) begin
      miscompares++; $display("FAIL state_prog: got %0d expected %0d", dbg_state, PROG);
    end
    for (int i = 0; i < n_rows; i++) begin
      cfg_we   = 1'b1;
      cfg_data = prog_d[i];
      cfg_mask = prog_m[i];
      #1;
      vectors++;
      if (cfg_done !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL prog_row%0d: got done=%0b ready=%0b expected 0 0", i, cfg_done, in_ready);
      end
      tick();
      model[i].data = 32'(prog_d[i]);
      model[i].mask = {{(32 - N_OUT){1'b1}}, prog_m[i]};
    end
    cfg_we = 1'b0;
    if (n_rows == ROWS) begin
      running = 1'b1;
      #1;
      vectors++;
      if (cfg_done !== 1'b1 || dbg_state !== RUN) begin
        miscompares++;
        $display("FAIL cfg_done_pulse: got done=%0b state=%0d expected 1 %0d", cfg_done, dbg_state, RUN);
      end
      tick();
      vectors++;
      if (cfg_done !== 1'b0) begin
        miscompares++; $display("FAIL cfg_done_single: got %0b expected 0", cfg_done);
      end
    end
  endtask

  task automatic run_stream(input int n_vec, input int ready_pct, input bit rand_vec,
                            input int start_vec, output int cycles);
    int sent = 0;
    int cyc  = 0;
    bit exp_rdy;
    int v;
    while ((sent < n_vec || exp_q.size() != 0) && cyc < 400) begin
      in_valid  = (sent < n_vec);
      in_vec    = rand_vec ? N_IN'($urandom_range(0, ROWS - 1)) : N_IN'(start_vec + sent);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      exp_rdy = running && (exp_q.size() == 0 || out_ready);
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++; $display("FAIL in_ready: got %0b expected %0b", in_ready, exp_rdy);
      end
      vectors++;
      if (out_valid !== (exp_q.size() != 0)) begin
        miscompares++;
        $display("FAIL out_valid: got %0b expected %0b", out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        vectors++;
        if ({out_dc, out_data_1, out_data} !== exp_q[0]) begin
          miscompares++;
          $display("FAIL result: got %0h expected %0h", {out_dc, out_data_1, out_data}, exp_q[0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        v = int'(in_vec);
        exp_q.push_back({ref_dc(v), ref_data(v, 1'b1), ref_data(v, 1'b0)});
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 400) begin
      vectors++; miscompares++;
      $display("FAIL stream_timeout: got %0d cycles expected under 400", cyc);
      exp_q.delete();
    end
    cycles = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_start = 1'b0; cfg_we = 1'b0; cfg_data = '0; cfg_mask = '0;
    in_valid = 1'b1; in_vec = '0; out_ready = 1'b0;
    model_reset();
    #12;
    vectors++;
    if ({cfg_done, cfg_err, in_ready, out_valid, out_data, out_dc} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {cfg_done, cfg_err, in_ready, out_valid, out_data, out_dc});
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL idle_blocked: got ready=%0b valid=%0b state=%0d expected 0 0 %0d",
               in_ready, out_valid, dbg_state, IDLE);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_program_basic();
    int cyc;
    for (int i = 0; i < ROWS; i++) begin
      prog_d[i] = (i == 0) ? 2'b10 : 2'b11;
      prog_m[i] = 2'b11;
    end
    program_table(1'b0, ROWS);
    run_stream(ROWS, 100, 1'b0, 0, cyc);
    vectors++;
    if (cyc !== ROWS + 1) begin
      miscompares++; $display("FAIL basic_throughput: got %0d cycles expected %0d", cyc, ROWS + 1);
    end
  endtask

  task automatic test_dontcare();
    int cyc;
    random_table();
    prog_d[3] = 2'b01;
    prog_m[3] = 2'b01;
    program_table(1'b1, ROWS);
    run_stream(1, 100, 1'b0, 3, cyc);
    run_stream(ROWS, 70, 1'b0, 0, cyc);
  endtask

  task automatic test_stall();
    logic [W-1:0] e;
    in_valid = 1'b1; in_vec = N_IN'($urandom_range(0, ROWS - 1)); out_ready = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL stall_accept: got %0b expected 1", in_ready);
    end
    e = {ref_dc(int'(in_vec)), ref_data(int'(in_vec), 1'b1), ref_data(int'(in_vec), 1'b0)};
    tick();
    for (int k = 0; k < 3; k++) begin
      in_vec = N_IN'($urandom_range(0, ROWS - 1));
      #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_dc, out_data_1, out_data} !== e) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got valid=%0b ready=%0b res=%0h expected 1 0 %0h",
                 k, out_valid, in_ready, {out_dc, out_data_1, out_data}, e);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL stall_drain: got %0b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    random_table();
    program_table(1'b0, ROWS);
    run_stream(40, 100, 1'b1, 0, cyc);
    vectors++;
    if (cyc !== 41) begin
      miscompares++; $display("FAIL b2b_throughput: got %0d cycles expected 41", cyc);
    end
    run_stream(40, 60, 1'b1, 0, cyc);
  endtask

  task automatic test_cfg_err();
    int cyc;
    cfg_we = 1'b1; cfg_data = ~model[0].data[N_OUT-1:0]; cfg_mask = '0;
    tick();
    cfg_we = 1'b0;
    tick();
    vectors++;
    if (cfg_err !== 1'b1 || dbg_state !== RUN) begin
      miscompares++;
      $display("FAIL cfg_err_set: got err=%0b state=%0d expected 1 %0d", cfg_err, dbg_state, RUN);
    end
    run_stream(ROWS, 100, 1'b0, 0, cyc);
  endtask

  task automatic test_start_pending();
    logic [W-1:0] e;
    in_valid = 1'b1; in_vec = N_IN'($urandom_range(0, ROWS - 1)); out_ready = 1'b0;
    e = {ref_dc(int'(in_vec)), ref_data(int'(in_vec), 1'b1), ref_data(int'(in_vec), 1'b0)};
    tick();
    in_valid = 1'b0; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0; running = 1'b0; in_valid = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || {out_dc, out_data_1, out_data} !== e || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_pending: got valid=%0b res=%0h ready=%0b expected 1 %0h 0",
               out_valid, {out_dc, out_data_1, out_data}, in_ready, e);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || dbg_state !== PROG) begin
      miscompares++;
      $display("FAIL start_drain: got valid=%0b state=%0d expected 0 %0d", out_valid, dbg_state, PROG);
    end
  endtask

  task automatic test_reset_mid_prog();
    int cyc;
    random_table();
    program_table(1'b0, 4);
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dbg_state !== IDLE || in_ready !== 1'b0 || cfg_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_prog_reset: got state=%0d ready=%0b done=%0b expected %0d 0 0",
               dbg_state, in_ready, cfg_done, IDLE);
    end
    #1;
    rst_n = 1'b1; in_valid = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_blocked: got ready=%0b valid=%0b expected 0 0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    random_table();
    program_table(1'b0, ROWS);
    run_stream(16, 80, 1'b1, 0, cyc);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_program_basic();
    test_dontcare();
    test_stall();
    test_back_to_back();
    test_cfg_err();
    test_start_pending();
    test_reset_mid_prog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
